// File: rtl/imem_pkg.sv
// Shared types and defaults for the instruction-memory access controller.
package imem_pkg;

    localparam int IMEM_ADDR_W     = 5;
    localparam int IMEM_STARVE_MAX = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_FETCH = 2'd2
    } state_e;

    // Fetch steps run 0..4: addresses go out in steps 0..3, bytes return in steps 1..4.
    localparam logic [2:0] FETCH_LAST_STEP = 3'd4;

endpackage

// File: rtl/imem_word_asm.sv
// Assembles four sequential bytes (lane 0 first) into a little-endian word that
// is only updated when the last byte arrives, so the output holds between fetches.
module imem_word_asm (
    input  logic        clk,
    input  logic        reset,
    input  logic        byte_vld_i,
    input  logic        byte_last_i,
    input  logic [7:0]  byte_i,
    output logic [31:0] word_o
);

    logic [23:0] shift_q;
    logic [31:0] word_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            shift_q <= '0;
            word_q  <= '0;
        end else if (byte_vld_i) begin
            // Lower three lanes shift in from the top, so lane 0 ends at the bottom.
            shift_q <= {byte_i, shift_q[23:8]};
            if (byte_last_i) begin
                word_q <= {byte_i, shift_q};
            end
        end
    end

    assign word_o = word_q;

endmodule

// File: rtl/imem_access_ctrl.sv
// Arbitrates a byte-wide instruction memory between a word-fetching core and a
// byte loader; fetches are issued as four sequential byte reads.
module imem_access_ctrl
    import imem_pkg::*;
#(
    parameter int ADDR_W     = IMEM_ADDR_W,
    parameter int STARVE_MAX = IMEM_STARVE_MAX
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              fetch_req,
    input  logic [31:0]       fetch_pc,
    output logic              fetch_gnt,
    output logic              instr_valid,
    output logic [31:0]       instr,
    output logic              fetch_misalign,
    input  logic              ld_req,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [7:0]        ld_data,
    output logic              ld_gnt,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [7:0]        mem_wdata,
    input  logic [7:0]        mem_rdata
);

    localparam int SW = $clog2(STARVE_MAX + 1);

    state_e            state_q, state_d;
    logic [2:0]        step_q, step_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic              pend_mis_q, pend_mis_d;
    logic [SW-1:0]     starve_q, starve_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [7:0]        mem_wdata_q, mem_wdata_d;
    logic              mem_we_q, mem_we_d;
    logic              valid_q, valid_d;
    logic              misalign_q, misalign_d;
    logic              asm_vld, asm_last;
    logic              starve_hit;
    logic              pc_hi_unused;

    assign pc_hi_unused = ^fetch_pc[31:ADDR_W];
    assign starve_hit   = fetch_req && (starve_q == SW'(STARVE_MAX));

    always_comb begin
        // NOTE: every combinational output gets a default first so no path infers a latch.
        state_d     = state_q;
        step_d      = step_q;
        pc_d        = pc_q;
        pend_mis_d  = pend_mis_q;
        starve_d    = starve_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_we_d    = 1'b0;
        valid_d     = 1'b0;
        misalign_d  = misalign_q;
        fetch_gnt   = 1'b0;
        ld_gnt      = 1'b0;
        asm_vld     = 1'b0;
        asm_last    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (!reset) begin
                    if (ld_req && !starve_hit) begin
                        ld_gnt      = 1'b1;
                        state_d     = ST_LOAD;
                        mem_addr_d  = ld_addr;
                        mem_wdata_d = ld_data;
                        mem_we_d    = 1'b1;
                        // A pending fetch implies the counter is below STARVE_MAX here.
                        if (fetch_req) begin
                            starve_d = starve_q + SW'(1);
                        end
                    end else if (fetch_req) begin
                        fetch_gnt  = 1'b1;
                        state_d    = ST_FETCH;
                        step_d     = '0;
                        pc_d       = fetch_pc[ADDR_W-1:0];
                        pend_mis_d = |fetch_pc[1:0];
                        mem_addr_d = fetch_pc[ADDR_W-1:0];
                        starve_d   = '0;
                    end
                end
            end
            ST_LOAD: begin
                state_d = ST_IDLE;
            end
            ST_FETCH: begin
                step_d = step_q + 3'd1;
                if (step_q < 3'd3) begin
                    mem_addr_d = pc_q + ADDR_W'(step_q + 3'd1);
                end
                asm_vld = (step_q != 3'd0);
                if (step_q == FETCH_LAST_STEP) begin
                    asm_last   = 1'b1;
                    state_d    = ST_IDLE;
                    step_d     = '0;
                    valid_d    = 1'b1;
                    misalign_d = pend_mis_q;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (reset) begin
            state_q     <= ST_IDLE;
            step_q      <= '0;
            pc_q        <= '0;
            pend_mis_q  <= 1'b0;
            starve_q    <= '0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_we_q    <= 1'b0;
            valid_q     <= 1'b0;
            misalign_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            step_q      <= step_d;
            pc_q        <= pc_d;
            pend_mis_q  <= pend_mis_d;
            starve_q    <= starve_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_we_q    <= mem_we_d;
            valid_q     <= valid_d;
            misalign_q  <= misalign_d;
        end
    end

    imem_word_asm u_word_asm (
        .clk        (clk),
        .reset      (reset),
        .byte_vld_i (asm_vld),
        .byte_last_i(asm_last),
        .byte_i     (mem_rdata),
        .word_o     (instr)
    );

    assign mem_addr       = mem_addr_q;
    assign mem_we         = mem_we_q;
    assign mem_wdata      = mem_wdata_q;
    assign instr_valid    = valid_q;
    assign fetch_misalign = misalign_q;

endmodule

// File: tb/tb_imem_access_ctrl.sv
// Directed bench for imem_access_ctrl with a behavioural byte memory.
module tb_imem_access_ctrl;

    localparam int AW = 5;
    localparam int SM = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          fetch_req;
    logic [31:0]   fetch_pc;
    logic          fetch_gnt;
    logic          instr_valid;
    logic [31:0]   instr;
    logic          fetch_misalign;
    logic          ld_req;
    logic [AW-1:0] ld_addr;
    logic [7:0]    ld_data;
    logic          ld_gnt;
    logic [AW-1:0] mem_addr;
    logic          mem_we;
    logic [7:0]    mem_wdata;
    logic [7:0]    mem_rdata;

    int total_cnt = 0;
    int pass_cnt  = 0;

    logic          pre_we = 1'b0;
    logic [AW-1:0] pre_addr = '0;
    logic [7:0]    pre_data = '0;
    logic [7:0]    mem [2**AW];

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (pre_we) mem[pre_addr] <= pre_data;
        else if (mem_we) mem[mem_addr] <= mem_wdata;
        mem_rdata <= mem[mem_addr];
    end

    imem_access_ctrl #(.ADDR_W(AW), .STARVE_MAX(SM)) dut (
        .clk           (clk),
        .reset         (reset),
        .fetch_req     (fetch_req),
        .fetch_pc      (fetch_pc),
        .fetch_gnt     (fetch_gnt),
        .instr_valid   (instr_valid),
        .instr         (instr),
        .fetch_misalign(fetch_misalign),
        .ld_req        (ld_req),
        .ld_addr       (ld_addr),
        .ld_data       (ld_data),
        .ld_gnt        (ld_gnt),
        .mem_addr      (mem_addr),
        .mem_we        (mem_we),
        .mem_wdata     (mem_wdata),
        .mem_rdata     (mem_rdata)
    );

    task automatic preload(input logic [AW-1:0] a, input logic [7:0] d);
        @(negedge clk);
        pre_we = 1'b1; pre_addr = a; pre_data = d;
        @(negedge clk);
        pre_we = 1'b0;
    endtask

    // Raises fetch_req and returns at negedge+1 of the grant cycle.
    task automatic start_fetch(input logic [31:0] pc, output bit ok);
        @(negedge clk);
        fetch_req = 1'b1; fetch_pc = pc;
        #1;
        for (int n = 0; n < 20 && fetch_gnt !== 1'b1; n++) begin
            @(negedge clk); #1;
        end
        ok = (fetch_gnt === 1'b1);
        total_cnt++;
        if (!ok) $display("FAIL fetch_grant_timeout pc=%h got fetch_gnt=%b want 1", pc, fetch_gnt);
        else pass_cnt++;
    endtask

    // Checks cycles T+1..T+7 after a fetch grant at T.
    task automatic finish_fetch(input logic [31:0] pc, input logic [31:0] exp_instr, input logic exp_mis);
        logic [AW-1:0] ea;
        for (int c = 1; c <= 7; c++) begin
            @(negedge clk);
            if (c == 1) fetch_req = 1'b0;
            #1;
            if (c <= 4) begin
                ea = pc[AW-1:0] + AW'(c - 1);
                total_cnt++;
                if (mem_addr !== ea || mem_we !== 1'b0)
                    $display("FAIL fetch_addr T+%0d got addr=%0d we=%b want addr=%0d we=0", c, mem_addr, mem_we, ea);
                else pass_cnt++;
            end
            if (c <= 5) begin
                total_cnt++;
                if ({fetch_gnt, ld_gnt} !== 2'b00)
                    $display("FAIL grant_in_fetch T+%0d got fetch_gnt=%b ld_gnt=%b want 0 0", c, fetch_gnt, ld_gnt);
                else pass_cnt++;
            end
            total_cnt++;
            if (instr_valid !== 1'(c == 6))
                $display("FAIL valid_timing T+%0d got instr_valid=%b want %b", c, instr_valid, (c == 6));
            else pass_cnt++;
            if (c >= 6) begin
                total_cnt++;
                if (instr !== exp_instr || fetch_misalign !== exp_mis)
                    $display("FAIL fetch_word pc=%h T+%0d got instr=%h mis=%b want instr=%h mis=%b",
                             pc, c, instr, fetch_misalign, exp_instr, exp_mis);
                else pass_cnt++;
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; fetch_req = 1'b1; fetch_pc = 32'd4;
        ld_req = 1'b1; ld_addr = 5'd3; ld_data = 8'h5A;
        repeat (2) @(negedge clk);
        #1;
        total_cnt++;
        if ({fetch_gnt, ld_gnt, instr_valid, mem_we, fetch_misalign, instr, mem_addr, mem_wdata} !== '0)
            $display("FAIL reset_outputs got gnt=%b%b v=%b we=%b mis=%b instr=%h addr=%0d wd=%h want all 0",
                     fetch_gnt, ld_gnt, instr_valid, mem_we, fetch_misalign, instr, mem_addr, mem_wdata);
        else pass_cnt++;
        reset = 1'b0; fetch_req = 1'b0; ld_req = 1'b0;
        @(negedge clk); #1;
        total_cnt++;
        if ({fetch_gnt, ld_gnt, mem_we, instr_valid} !== 4'b0000)
            $display("FAIL idle_after_reset got gnt=%b%b we=%b v=%b want 0", fetch_gnt, ld_gnt, mem_we, instr_valid);
        else pass_cnt++;
    endtask

    task automatic test_back_to_back_load();
        logic [4:0] pat;
        pat = '0;
        @(negedge clk);
        ld_req = 1'b1; ld_addr = 5'd12; ld_data = 8'h3C;
        for (int c = 0; c < 5; c++) begin
            #1;
            pat[c] = ld_gnt;
            @(negedge clk);
        end
        ld_req = 1'b0;
        total_cnt++;
        if (pat !== 5'b10101) $display("FAIL b2b_load_pattern got %b want 10101", pat);
        else pass_cnt++;
        @(negedge clk);
    endtask

    task automatic test_basic_fetch();
        bit ok;
        preload(5'd0, 8'h23); preload(5'd1, 8'h20); preload(5'd2, 8'h50); preload(5'd3, 8'h00);
        start_fetch(32'd0, ok);
        if (ok) finish_fetch(32'd0, 32'h0050_2023, 1'b0);
    endtask

    task automatic test_ld_vs_fetch();
        bit ok;
        preload(5'd8, 8'hFF); preload(5'd9, 8'h01); preload(5'd10, 8'h02); preload(5'd11, 8'h03);
        @(negedge clk);
        ld_req = 1'b1; ld_addr = 5'd8; ld_data = 8'hA5;
        fetch_req = 1'b1; fetch_pc = 32'd8;
        #1;
        total_cnt++;
        if ({ld_gnt, fetch_gnt} !== 2'b10)
            $display("FAIL both_req_T got ld_gnt=%b fetch_gnt=%b want 1 0", ld_gnt, fetch_gnt);
        else pass_cnt++;
        @(negedge clk);
        ld_req = 1'b0;
        #1;
        total_cnt++;
        if ({mem_we, mem_addr, mem_wdata, ld_gnt, fetch_gnt} !== {1'b1, 5'd8, 8'hA5, 2'b00})
            $display("FAIL load_T1 got we=%b addr=%0d wd=%h gnt=%b%b want we=1 addr=8 wd=a5 gnt=00",
                     mem_we, mem_addr, mem_wdata, ld_gnt, fetch_gnt);
        else pass_cnt++;
        @(negedge clk); #1;
        ok = (fetch_gnt === 1'b1);
        total_cnt++;
        if (!ok) $display("FAIL fetch_gnt_T2 got %b want 1", fetch_gnt);
        else pass_cnt++;
        if (ok) finish_fetch(32'd8, 32'h0302_01A5, 1'b0);
    endtask

    task automatic test_starvation();
        int ld_n;
        int gnt_cyc;
        ld_n = 0; gnt_cyc = -1;
        preload(5'd16, 8'h10); preload(5'd17, 8'h32); preload(5'd18, 8'h54); preload(5'd19, 8'h76);
        @(negedge clk);
        ld_req = 1'b1; ld_addr = 5'd20; ld_data = 8'h77;
        fetch_req = 1'b1; fetch_pc = 32'd16;
        for (int c = 0; c < 20; c++) begin
            #1;
            if (fetch_gnt === 1'b1) begin
                gnt_cyc = c;
                break;
            end
            if (ld_gnt === 1'b1) ld_n++;
            @(negedge clk);
        end
        ld_req = 1'b0;
        total_cnt++;
        if (ld_n != SM) $display("FAIL starve_ld_count got %0d want %0d", ld_n, SM);
        else pass_cnt++;
        total_cnt++;
        if (gnt_cyc != 8) $display("FAIL starve_fetch_cycle got %0d want 8", gnt_cyc);
        else pass_cnt++;
        if (gnt_cyc >= 0) finish_fetch(32'd16, 32'h7654_3210, 1'b0);
        else fetch_req = 1'b0;
    endtask

    task automatic test_wrap();
        bit ok;
        preload(5'd30, 8'h11); preload(5'd31, 8'h22); preload(5'd0, 8'h33); preload(5'd1, 8'h44);
        start_fetch(32'd30, ok);
        if (ok) finish_fetch(32'd30, 32'h4433_2211, 1'b1);
    endtask

    task automatic test_high_pc();
        bit ok;
        preload(5'd4, 8'hDE); preload(5'd5, 8'hAD); preload(5'd6, 8'hBE); preload(5'd7, 8'hEF);
        start_fetch(32'h0000_0024, ok);
        if (ok) finish_fetch(32'h0000_0024, 32'hEFBE_ADDE, 1'b0);
    endtask

    task automatic test_reset_mid_fetch();
        bit ok;
        bit seen_valid;
        seen_valid = 1'b0;
        start_fetch(32'd4, ok);
        @(negedge clk); fetch_req = 1'b0;
        @(negedge clk);
        @(negedge clk); reset = 1'b1;
        #1;
        if (instr_valid === 1'b1) seen_valid = 1'b1;
        @(negedge clk); #1;
        total_cnt++;
        if ({fetch_gnt, ld_gnt, instr_valid, mem_we, fetch_misalign, instr, mem_addr, mem_wdata} !== '0)
            $display("FAIL mid_fetch_reset_outputs got v=%b we=%b mis=%b instr=%h addr=%0d wd=%h want all 0",
                     instr_valid, mem_we, fetch_misalign, instr, mem_addr, mem_wdata);
        else pass_cnt++;
        @(negedge clk); reset = 1'b0;
        for (int c = 0; c < 5; c++) begin
            #1;
            if (instr_valid === 1'b1) seen_valid = 1'b1;
            @(negedge clk);
        end
        total_cnt++;
        if (seen_valid) $display("FAIL mid_fetch_discard got instr_valid=1 want 0");
        else pass_cnt++;
        start_fetch(32'd4, ok);
        if (ok) finish_fetch(32'd4, 32'hEFBE_ADDE, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1);
    end

    initial begin
        reset = 1'b1; fetch_req = 1'b0; fetch_pc = '0;
        ld_req = 1'b0; ld_addr = '0; ld_data = '0;
        test_reset();
        test_back_to_back_load();
        test_basic_fetch();
        test_ld_vs_fetch();
        test_starvation();
        test_wrap();
        test_high_pc();
        test_reset_mid_fetch();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/imem_access_ctrl.md
IMEM_ACCESS_CTRL -- requirements
Module: imem_access_ctrl

Interface
REQ-001 Parameter: ADDR_W, default 5, byte-address width of instruction memory (depth 2**ADDR_W bytes).
REQ-002 Parameter: STARVE_MAX, default 4, consecutive loader grants allowed while a fetch is pending.
REQ-003 clk  input  1  rising-edge clock.
REQ-004 reset  input  1  reset, synchronous, active-high.
REQ-005 fetch_req  input  1  core requests a 32-bit instruction fetch; held until fetch_gnt.
REQ-006 fetch_pc  input  32  byte address of the instruction; sampled on the fetch_gnt cycle.
REQ-007 fetch_gnt  output  1  fetch accepted this cycle.
REQ-008 instr_valid  output  1  one-cycle pulse; instr and fetch_misalign are valid.
REQ-009 instr  output  32  little-endian word {byte pc+3, pc+2, pc+1, pc}.
REQ-010 fetch_misalign  output  1  accepted fetch_pc[1:0] was non-zero.
REQ-011 ld_req  input  1  loader requests a byte write; held until ld_gnt.
REQ-012 ld_addr  input  ADDR_W  write byte address; sampled on the ld_gnt cycle.
REQ-013 ld_data  input  8  write byte; sampled on the ld_gnt cycle.
REQ-014 ld_gnt  output  1  loader write accepted this cycle.
REQ-015 mem_addr  output  ADDR_W  byte address to the memory, registered.
REQ-016 mem_we  output  1  write strobe, registered.
REQ-017 mem_wdata  output  8  write data, registered.
REQ-018 mem_rdata  input  8  read data, valid the cycle after mem_addr is presented with mem_we=0.

Function
REQ-019 FSM states: IDLE, LOAD, FETCH; grants are issued only in IDLE, combinationally from the request inputs.
REQ-020 IDLE, ld_req=1: ld_gnt=1 and go to LOAD, unless the starvation rule (REQ-022) applies.
REQ-021 IDLE, fetch_req=1 and no loader grant this cycle: fetch_gnt=1 and go to FETCH.
REQ-022 Starvation counter increments on each ld_gnt while fetch_req=1, and clears on fetch_gnt; when it equals STARVE_MAX, fetch wins over ld_req.
REQ-023 LOAD (one cycle): mem_we=1, mem_addr/mem_wdata = sampled ld_addr/ld_data; then return to IDLE; at most one write per two cycles.
REQ-024 FETCH: a 2-bit byte counter i=0..3 presents mem_addr = (fetch_pc[ADDR_W-1:0]+i) mod 2**ADDR_W, one address per cycle, in cycles T+1..T+4 where T is the grant cycle.
REQ-025 The byte returned in cycle T+2+i is stored in instr lane i; instr_valid pulses in cycle T+6; the state is IDLE from cycle T+6.
REQ-026 Fetch latency is grant to instr_valid = 6 cycles; fetch_gnt is never asserted during FETCH or LOAD.
REQ-027 Address wrap: a fetch at byte address 2**ADDR_W-2 reads bytes 2**ADDR_W-2, 2**ADDR_W-1, 0, 1.
REQ-028 fetch_pc bits above ADDR_W-1 are ignored; a misaligned fetch is still performed and sets fetch_misalign with instr_valid.
REQ-029 instr holds its value until the next instr_valid; mem_we=0 in every cycle outside LOAD.
REQ-030 Requests that drop before grant are ignored; no request is queued internally.

Reset
REQ-031 While reset=1: state IDLE; fetch_gnt, ld_gnt, instr_valid, mem_we and fetch_misalign are 0; instr, mem_addr, mem_wdata and the counters are 0.
REQ-032 Reset mid-FETCH discards the partial word with no instr_valid; reset mid-LOAD suppresses mem_we in the following cycle.

Structure
REQ-033 The FSM state enum and the default values of ADDR_W and STARVE_MAX reside in the shared package imem_pkg.
REQ-034 Byte-lane assembly of instr (shift or lane-enable register) is the single sub-module imem_word_asm; all other logic is flat.

Verification
REQ-035 Memory preloaded with 0x00502023 at byte 0; fetch_pc=0 granted at T -> instr=0x00502023, instr_valid at T+6, fetch_misalign=0.
REQ-036 ld_req and fetch_req both asserted in IDLE -> ld_gnt first, mem_we at T+1, fetch_gnt at T+2, and the fetch returns the newly written byte.
REQ-037 ld_req held continuously with fetch_req pending, STARVE_MAX=4 -> exactly 4 ld_gnt, then fetch_gnt.
REQ-038 ADDR_W=5, bytes 30,31,0,1 = 0x11,0x22,0x33,0x44; fetch_pc=30 -> instr=0x44332211, fetch_misalign=1.
REQ-039 reset asserted at T+3 of a fetch -> no instr_valid and all outputs 0; a new fetch granted after reset completes normally.
REQ-040 fetch_pc=0x0000_0024 with ADDR_W=5 -> reads bytes 4..7 and instr equals the word at byte address 4.
